// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with programmable terminal value, wrap/saturate
// modes, cascade carry chaining, a registered wrap pulse and a sticky overflow flag.
module up_down_counter_mod #(
  parameter int unsigned   N       = 8,
  parameter logic [N-1:0]  MAX_RST = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en_b,
  input  logic         cin_b,
  input  logic         load_b,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] load_in,
  input  logic         max_we,
  input  logic [N-1:0] max_in,
  output logic [N-1:0] q,
  output logic [N-1:0] max_q,
  output logic         rco_b,
  output logic         wrap_p,
  output logic         ovf
);

  logic         cnt;
  logic         term;
  logic [N-1:0] q_nxt;
  logic         wrap_nxt;
  logic         ovf_nxt;

  // Count qualifier and terminal detection; up-terminal also covers q loaded above max_q.
  assign cnt   = ~en_b & ~cin_b;
  assign term  = up ? (q >= max_q) : (q == '0);
  assign rco_b = ~(cnt & term);

  // Next-state selection: load beats counting; terminal count wraps or saturates.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (!load_b) begin
      q_nxt   = load_in;
      ovf_nxt = 1'b0;
    end else if (cnt) begin
      if (!term) begin
        q_nxt = up ? (q + N'(1)) : (q - N'(1));
      end else if (sat) begin
        q_nxt   = up ? max_q : '0;
        ovf_nxt = 1'b1;
      end else begin
        q_nxt    = up ? '0 : max_q;
        wrap_nxt = 1'b1;
        ovf_nxt  = 1'b1;
      end
    end
  end

  // State registers; max_q write is independent of load/count priority.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q      <= '0;
      max_q  <= MAX_RST;
      wrap_p <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      q      <= q_nxt;
      wrap_p <= wrap_nxt;
      ovf    <= ovf_nxt;
      if (max_we) begin
        max_q <= max_in;
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Self-checking bench for up_down_counter_mod: directed scenarios plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_up_down_counter_mod;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_b, en_b, cin_b, load_b, up, sat, max_we;
  logic [N-1:0] load_in, max_in, q, max_q;
  logic         rco_b, wrap_p, ovf;

  logic         c_en_b, c_load_b;
  logic [N-1:0] c_lo_in, c_hi_in, c_lo_q, c_hi_q, c_lo_max, c_hi_max;
  logic         c_lo_rco, c_hi_rco, c_lo_wrap, c_hi_wrap, c_lo_ovf, c_hi_ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_q, m_max;
  bit m_wrap, m_ovf;

  up_down_counter_mod #(.N(N)) dut (
    .clk(clk), .rst_b(rst_b), .en_b(en_b), .cin_b(cin_b), .load_b(load_b),
    .up(up), .sat(sat), .load_in(load_in), .max_we(max_we), .max_in(max_in),
    .q(q), .max_q(max_q), .rco_b(rco_b), .wrap_p(wrap_p), .ovf(ovf)
  );

  up_down_counter_mod #(.N(N)) u_lo (
    .clk(clk), .rst_b(rst_b), .en_b(c_en_b), .cin_b(1'b0), .load_b(c_load_b),
    .up(1'b1), .sat(1'b0), .load_in(c_lo_in), .max_we(1'b0), .max_in(4'd0),
    .q(c_lo_q), .max_q(c_lo_max), .rco_b(c_lo_rco), .wrap_p(c_lo_wrap), .ovf(c_lo_ovf)
  );

  up_down_counter_mod #(.N(N)) u_hi (
    .clk(clk), .rst_b(rst_b), .en_b(c_en_b), .cin_b(c_lo_rco), .load_b(c_load_b),
    .up(1'b1), .sat(1'b0), .load_in(c_hi_in), .max_we(1'b0), .max_in(4'd0),
    .q(c_hi_q), .max_q(c_hi_max), .rco_b(c_hi_rco), .wrap_p(c_hi_wrap), .ovf(c_hi_ovf)
  );

  function automatic bit exp_rco();
    bit counting, at_end;
    counting = !en_b && !cin_b;
    at_end   = up ? (m_q >= m_max) : (m_q == 0);
    return !(counting && at_end);
  endfunction

  function automatic logic [2*N+1:0] exp_vec();
    return {N'(m_q), N'(m_max), m_wrap, m_ovf};
  endfunction

  // Advance one clock edge and the model by one step from the current inputs.
  task automatic tick();
    int nq, nmax;
    bit nwrap, novf;
    nq = m_q; nmax = m_max; nwrap = 1'b0; novf = m_ovf;
    if (!rst_b) begin
      nq = 0; nmax = (1 << N) - 1; novf = 1'b0;
    end else begin
      if (max_we) nmax = int'(max_in);
      if (!load_b) begin
        nq = int'(load_in); novf = 1'b0;
      end else if (!en_b && !cin_b) begin
        if (up) begin
          if (m_q < m_max) nq = m_q + 1;
          else if (sat) begin nq = m_max; novf = 1'b1; end
          else begin nq = 0; nwrap = 1'b1; novf = 1'b1; end
        end else begin
          if (m_q != 0) nq = m_q - 1;
          else if (sat) begin nq = 0; novf = 1'b1; end
          else begin nq = m_max; nwrap = 1'b1; novf = 1'b1; end
        end
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_max = nmax; m_wrap = nwrap; m_ovf = novf;
  endtask

  task automatic set_idle();
    rst_b = 1'b1; en_b = 1'b1; cin_b = 1'b0; load_b = 1'b1; up = 1'b1; sat = 1'b0;
    max_we = 1'b0; load_in = '0; max_in = '0;
    c_en_b = 1'b1; c_load_b = 1'b1; c_lo_in = '0; c_hi_in = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_b = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    checks++;
    if ({q, max_q, wrap_p, ovf} !== {4'd0, 4'd15, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got q=%0d max_q=%0d wrap_p=%b ovf=%b, want q=0 max_q=15 wrap_p=0 ovf=0",
               q, max_q, wrap_p, ovf);
    end
  endtask

  task automatic test_wrap_up();
    int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    set_idle();
    max_we = 1'b1; max_in = 4'd9;
    tick();
    max_we = 1'b0; en_b = 1'b0; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({q, wrap_p, ovf} !== {4'(exp_q[i]), (i == 9), (i >= 9)}) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got q=%0d wrap_p=%b ovf=%b, want q=%0d wrap_p=%b ovf=%b",
                 i, q, wrap_p, ovf, exp_q[i], (i == 9), (i >= 9));
      end
    end
    set_idle();
  endtask

  task automatic test_saturate();
    set_idle();
    load_b = 1'b0; load_in = 4'd8;
    tick();
    load_b = 1'b1; en_b = 1'b0; up = 1'b1; sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({q, wrap_p, ovf} !== {4'd9, 1'b0, (i >= 1)}) begin
        errors++;
        $display("FAIL sat_up[%0d]: got q=%0d wrap_p=%b ovf=%b, want q=9 wrap_p=0 ovf=%b",
                 i, q, wrap_p, ovf, (i >= 1));
      end
    end
    en_b = 1'b1; load_b = 1'b0; load_in = 4'd1;
    tick();
    load_b = 1'b1; en_b = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({q, wrap_p, ovf} !== {4'd0, 1'b0, (i >= 1)}) begin
        errors++;
        $display("FAIL sat_down[%0d]: got q=%0d wrap_p=%b ovf=%b, want q=0 wrap_p=0 ovf=%b",
                 i, q, wrap_p, ovf, (i >= 1));
      end
    end
    set_idle();
  endtask

  task automatic test_load_above_max();
    set_idle();
    max_we = 1'b1; max_in = 4'd5; load_b = 1'b0; load_in = 4'd12;
    tick();
    max_we = 1'b0; load_b = 1'b1; en_b = 1'b0; up = 1'b1; sat = 1'b0;
    #1;
    checks++;
    if (rco_b !== 1'b0) begin
      errors++;
      $display("FAIL above_max_rco: got rco_b=%b, want 0", rco_b);
    end
    tick();
    checks++;
    if ({q, wrap_p} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL above_max_wrap: got q=%0d wrap_p=%b, want q=0 wrap_p=1", q, wrap_p);
    end
    en_b = 1'b1; load_b = 1'b0; load_in = 4'd12;
    tick();
    load_b = 1'b1; en_b = 1'b0; sat = 1'b1;
    tick();
    checks++;
    if ({q, wrap_p, ovf} !== {4'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL above_max_sat: got q=%0d wrap_p=%b ovf=%b, want q=5 wrap_p=0 ovf=1",
               q, wrap_p, ovf);
    end
    set_idle();
  endtask

  task automatic test_down_wrap_rco();
    set_idle();
    max_we = 1'b1; max_in = 4'd9; load_b = 1'b0; load_in = 4'd0;
    tick();
    max_we = 1'b0; load_b = 1'b1; up = 1'b0; en_b = 1'b0; cin_b = 1'b0;
    #1;
    checks++;
    if (rco_b !== 1'b0) begin
      errors++;
      $display("FAIL down_rco_low: got rco_b=%b, want 0", rco_b);
    end
    tick();
    checks++;
    if ({q, wrap_p, ovf} !== {4'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL down_wrap: got q=%0d wrap_p=%b ovf=%b, want q=9 wrap_p=1 ovf=1", q, wrap_p, ovf);
    end
    load_b = 1'b0; load_in = 4'd0;
    tick();
    load_b = 1'b1; cin_b = 1'b1;
    #1;
    checks++;
    if (rco_b !== 1'b1) begin
      errors++;
      $display("FAIL cin_rco_high: got rco_b=%b, want 1", rco_b);
    end
    tick();
    checks++;
    if ({q, wrap_p} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL cin_hold: got q=%0d wrap_p=%b, want q=0 wrap_p=0", q, wrap_p);
    end
    set_idle();
  endtask

  task automatic test_cascade();
    int exp_v[3] = '{8'h0F, 8'h10, 8'h11};
    set_idle();
    c_load_b = 1'b0; c_lo_in = 4'hE; c_hi_in = 4'h0;
    tick();
    c_load_b = 1'b1; c_en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({c_hi_q, c_lo_q} !== 8'(exp_v[i])) begin
        errors++;
        $display("FAIL cascade[%0d]: got 0x%02h, want 0x%02h", i, {c_hi_q, c_lo_q}, exp_v[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_collisions();
    set_idle();
    // Load plus count: load wins and clears ovf.
    max_we = 1'b1; max_in = 4'd9; load_b = 1'b0; load_in = 4'd9;
    tick();
    max_we = 1'b0; load_b = 1'b1; en_b = 1'b0; up = 1'b1;
    tick();
    load_b = 1'b0; load_in = 4'd6;
    tick();
    checks++;
    if ({q, ovf, wrap_p} !== {4'd6, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_vs_count: got q=%0d ovf=%b wrap_p=%b, want q=6 ovf=0 wrap_p=0", q, ovf, wrap_p);
    end
    // max_we plus wrapping count: wrap uses old max, new max visible next.
    load_in = 4'd9;
    tick();
    load_b = 1'b1; max_we = 1'b1; max_in = 4'd3;
    tick();
    max_we = 1'b0; en_b = 1'b1;
    checks++;
    if ({q, max_q, wrap_p} !== {4'd0, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL maxwe_vs_wrap: got q=%0d max_q=%0d wrap_p=%b, want q=0 max_q=3 wrap_p=1",
               q, max_q, wrap_p);
    end
    // Reset plus load and max write: reset wins.
    rst_b = 1'b0; load_b = 1'b0; load_in = 4'd7; max_we = 1'b1; max_in = 4'd2; en_b = 1'b0;
    tick();
    checks++;
    if ({q, max_q, ovf} !== {4'd0, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL reset_vs_load: got q=%0d max_q=%0d ovf=%b, want q=0 max_q=15 ovf=0", q, max_q, ovf);
    end
    set_idle();
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 400; i++) begin
      rst_b   = ($urandom_range(0, 59) != 0);
      load_b  = ($urandom_range(0, 9) != 0);
      en_b    = ($urandom_range(0, 3) == 0);
      cin_b   = ($urandom_range(0, 5) == 0);
      up      = 1'($urandom_range(0, 1));
      sat     = 1'($urandom_range(0, 1));
      max_we  = ($urandom_range(0, 11) == 0);
      load_in = 4'($urandom_range(0, 15));
      max_in  = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (rco_b !== exp_rco()) begin
        errors++;
        $display("FAIL rand_rco[%0d]: got rco_b=%b, want %b", i, rco_b, exp_rco());
      end
      tick();
      checks++;
      if ({q, max_q, wrap_p, ovf} !== exp_vec()) begin
        errors++;
        $display("FAIL rand_state[%0d]: got q=%0d max_q=%0d wrap_p=%b ovf=%b, want q=%0d max_q=%0d wrap_p=%b ovf=%b",
                 i, q, max_q, wrap_p, ovf, m_q, m_max, m_wrap, m_ovf);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    #2;
    test_reset();
    test_wrap_up();
    test_saturate();
    test_load_above_max();
    test_down_wrap_rco();
    test_cascade();
    test_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_counter_mod.md
# up_down_counter_mod

Parametrised up/down counter with a programmable terminal value, wrap or saturate mode, cascade carry-in, a registered wrap pulse and a sticky overflow flag. It succeeds the fixed-range 4-bit up/down counter. It serves timer, prescaler and address-sequencing slices, and several instances can be chained through `cin_b`/`rco_b` to build wider counters.

## Interface
- `N`, 8: counter width in bits, N >= 2.
- `MAX_RST`, 2**N-1: reset value of the terminal register `max_q`.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_b` input 1: synchronous active-low reset. The reset is synchronous and active-low; it is sampled on the `clk` rising edge.
- `en_b` input 1: active-low count enable.
- `cin_b` input 1: active-low cascade carry-in. Tie it low on the least-significant stage.
- `load_b` input 1: active-low synchronous load of `load_in` into `q`.
- `up` input 1: count direction; 1 = up, 0 = down.
- `sat` input 1: mode; 1 = saturate at the terminal value, 0 = wrap.
- `load_in` input N: value loaded into `q`.
- `max_we` input 1: active-high write strobe for the terminal register.
- `max_in` input N: new terminal value.
- `q` output N: counter value.
- `max_q` output N: current terminal value.
- `rco_b` output 1: active-low ripple carry-out (combinational).
- `wrap_p` output 1: registered one-cycle pulse following a wrap.
- `ovf` output 1: sticky flag; set on a wrap or a saturation hit.

## Operation
- `cnt` = `~en_b & ~cin_b`, the count qualifier.
- `term` = (`up` & `q` >= `max_q`) | (`~up` & `q` == 0).
- Per-edge priority: `rst_b` low, then `load_b` low, then counting. The `max_q` write is independent of this priority.
- Reset:
  - `q` = 0, `max_q` = `MAX_RST`, `wrap_p` = 0, `ovf` = 0.
  - A reset overrides a simultaneous load, `max_we` and count.
- Load (`load_b` = 0):
  - `q` <= `load_in` verbatim, with no clamping to `max_q`.
  - `ovf` <= 0 and `wrap_p` <= 0.
  - A load ignores `en_b` and `cin_b`.
- Count (`cnt` = 1, no load):
  - Up, `q` < `max_q`: `q` <= `q`+1.
  - Down, `q` != 0: `q` <= `q`-1.
  - Up with `term` and `sat` = 0: `q` <= 0; `wrap_p` <= 1; `ovf` <= 1.
  - Down with `term` and `sat` = 0: `q` <= `max_q`; `wrap_p` <= 1; `ovf` <= 1.
  - Up with `term` and `sat` = 1: `q` <= `max_q`, which clamps a value above `max_q`; `ovf` <= 1; `wrap_p` <= 0.
  - Down with `term` and `sat` = 1: `q` holds at 0; `ovf` <= 1; `wrap_p` <= 0.
- Idle (`cnt` = 0, no load): `q` and `ovf` hold; `wrap_p` <= 0.
- Terminal write:
  - `max_we` = 1 and `rst_b` = 1: `max_q` <= `max_in`.
  - A count in the same cycle uses the old `max_q`.
  - `max_in` = 0 is legal: up-count then wraps or holds at 0 on every enabled edge.
- `rco_b` = ~(`cnt` & `term`).
  - It is purely combinational from `q`, `max_q`, `up`, `en_b` and `cin_b`.
  - A downstream stage takes this `rco_b` as its `cin_b`.
- Arithmetic is modulo 2**N internally. Only the rules above decide the next `q`; no carry leaves the N-bit range except through `rco_b`.

## Timing
- `q` changes one edge after qualifying inputs.
- `wrap_p` is high for exactly the cycle after the wrapping edge. Back-to-back wraps (e.g. `max_q` = 0) hold it high continuously.
- `ovf` is visible one edge after the wrap or saturation event. It stays high until a reset or a load.
- `rco_b` is valid in the same cycle as its inputs, with no register.
- Reset mid-count takes effect on the next edge; the count interrupted by the reset is lost.
- Simultaneous load and count: the load wins.
- A direction change takes effect on the edge where the new `up` is sampled, with no pipeline delay.

## Test plan
- Reset and wrap-up, N=4:
  - Stimulus: `rst_b` low 2 cycles, then `max_we` with `max_in`=9, then count up with `sat`=0 for 12 edges.
  - Required: `q` = 0, `max_q` = 15 after reset; then `q` runs 1..9, 0, 1, 2; `wrap_p` is high only the cycle after 9→0; `ovf` is 1 from then on.
- Saturate both directions, `max_q`=9:
  - Stimulus: load 8, count up with `sat`=1 for 3 edges; then count down from load 1 for 3 edges.
  - Required: `q` = 9, 9, 9 with `ovf` set and `wrap_p` never high; then `q` = 0, 0, 0.
- Load above max:
  - Stimulus: `max_q`=5, load 12. Count up with `sat`=0 for one edge, then reload 12 and count up with `sat`=1 for one edge.
  - Required: `rco_b` low while counting at `q`=12; first edge gives `q`=0; second sequence gives `q`=5.
- Down wrap and `rco_b`:
  - Stimulus: `max_q`=9, `q`=0, down, `en_b`=0, `cin_b`=0.
  - Required: `rco_b`=0 combinationally; next `q`=9; raising `cin_b` forces `rco_b`=1 and holds `q`.
- Cascade of two N=4 stages at max 15:
  - Stimulus: count up from 0x0E for 3 edges.
  - Required: concatenated value goes 0x0F, 0x10, 0x11.
- Collisions:
  - Load plus count in one edge: `q` = `load_in`, `ovf` = 0.
  - `max_we` plus wrapping count: the wrap uses the old max, and the new `max_q` is visible next cycle.
  - Reset plus load: `q` = 0.
